// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-side types: word, RAM status and the memory grant state.
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2
   } grant_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Data-first priority pick with an anti-starvation counter for the instruction side.
module mem_arb_prio
   import cpu_types_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   ireq,
   input  logic   dreq,
   input  logic   d_done,
   input  logic   i_done,
   output grant_t pick_c
);

   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   logic [SW-1:0] starve;
   logic          starved;

   always_comb begin
      starved = ireq && (starve == SW'(STARVE_MAX));
      pick_c  = IDLE;
      if (dreq && !starved) begin
         pick_c = DGRANT;
      end else if (ireq) begin
         pick_c = IGRANT;
      end
   end

   // Counts data completions that happened while the icache was waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve <= '0;
      end else if (i_done || (d_done && !ireq)) begin
         starve <= '0;
      end else if (d_done && (starve != SW'(STARVE_MAX))) begin
         starve <= starve + SW'(1);
      end
   end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Memory-side responder: arbitrates icache/dcache requests onto one RAM port
// and completes the iwait/dwait handshakes combinationally on RAM status.
module cache_mem_ctrl
   import cpu_types_pkg::*;
#(
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned STARVE_MAX = 4,
   parameter word_t       ERR_WORD   = 32'hBAD1BAD1
) (
   input  logic      CLK,
   input  logic      RST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      err
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   grant_t        state;
   grant_t        state_nxt;
   grant_t        pick_c;
   logic [TW-1:0] tcnt;
   logic [TW-1:0] tcnt_nxt;
   logic          dreq;
   logic          hit;
   logic          finish;
   logic          d_done;
   logic          i_done;
   logic          fault;

   mem_arb_prio #(
      .STARVE_MAX(STARVE_MAX)
   ) u_arb (
      .clk   (CLK),
      .rst   (RST),
      .ireq  (iREN),
      .dreq  (dreq),
      .d_done(d_done),
      .i_done(i_done),
      .pick_c(pick_c)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         tcnt  <= '0;
      end else begin
         state <= state_nxt;
         tcnt  <= tcnt_nxt;
      end
   end

   // A grant finishes on ACCESS, on ERROR, or when the timeout budget runs out.
   always_comb begin
      dreq      = dREN | dWEN;
      hit       = (ramstate == ACCESS);
      finish    = hit || (ramstate == ERROR) || (tcnt == TW'(TIMEOUT - 1));
      state_nxt = state;
      tcnt_nxt  = tcnt;
      iwait     = 1'b1;
      dwait     = 1'b1;
      iload     = '0;
      dload     = '0;
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      ramaddr   = '0;
      ramstore  = '0;
      d_done    = 1'b0;
      i_done    = 1'b0;
      fault     = 1'b0;
      unique case (state)
         IDLE: begin
            tcnt_nxt  = '0;
            state_nxt = pick_c;
         end
         DGRANT: begin
            if (!dreq) begin
               state_nxt = IDLE;
            end else begin
               ramaddr  = daddr;
               ramWEN   = dWEN;
               ramREN   = !dWEN;
               ramstore = dWEN ? dstore : '0;
               if (finish) begin
                  dwait     = 1'b0;
                  dload     = hit ? ramload : ERR_WORD;
                  d_done    = 1'b1;
                  fault     = !hit;
                  state_nxt = IDLE;
               end else begin
                  tcnt_nxt = tcnt + TW'(1);
               end
            end
         end
         IGRANT: begin
            if (!iREN) begin
               state_nxt = IDLE;
            end else begin
               ramaddr = iaddr;
               ramREN  = 1'b1;
               if (finish) begin
                  iwait     = 1'b0;
                  iload     = hit ? ramload : ERR_WORD;
                  i_done    = 1'b1;
                  fault     = !hit;
                  state_nxt = IDLE;
               end else begin
                  tcnt_nxt = tcnt + TW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Sticky error: only reset clears it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         err <= 1'b0;
      end else if (fault) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl: requester drivers push expected loads,
// a negedge monitor pops them on each wait pulse; a small RAM model serves the port.
module tb_cache_mem_ctrl;
   import cpu_types_pkg::*;

   localparam word_t ERR_W = 32'hBAD1BAD1;

   typedef struct {
      bit    is_read;
      bit    fault;
      word_t load;
   } exp_t;

   logic      CLK = 1'b0;
   logic      RST = 1'b1;
   logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
   word_t     iaddr = '0, daddr = '0, dstore = '0;
   logic      iwait, dwait, ramREN, ramWEN, err;
   word_t     iload, dload, ramaddr, ramstore, ramload;
   ramstate_t ramstate = FREE;

   exp_t  dq[$];
   exp_t  iq[$];
   exp_t  me;
   byte   log_q[$];
   word_t mem[16];
   word_t model[16];
   int    tests = 0;
   int    failed = 0;
   bit    sticky = 0;
   bit    hang = 0;
   bit    err_mode = 0;
   int    busy_left = 0;
   int    force_lat = 0;

   cache_mem_ctrl dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   always #5 CLK = ~CLK;

   assign ramload = mem[ramaddr[3:0]];

   task automatic chk(input string name, input word_t act, input word_t exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor first, then RAM bookkeeping for the cycle just observed.
   always @(negedge CLK) begin
      if (!RST) begin
         if (!dwait) begin
            if (dq.size() == 0) begin
               tests++; failed++;
               $display("FAIL d_unexpected: got dwait=0, expected no completion");
            end else begin
               me = dq.pop_front();
               if (me.is_read) chk("dload", dload, me.load);
               chk("err_at_dcomp", word_t'(err), word_t'(sticky));
               if (me.fault) sticky = 1'b1;
               log_q.push_back(8'h44);
            end
         end
         if (!iwait) begin
            if (iq.size() == 0) begin
               tests++; failed++;
               $display("FAIL i_unexpected: got iwait=0, expected no completion");
            end else begin
               me = iq.pop_front();
               chk("iload", iload, me.load);
               chk("err_at_icomp", word_t'(err), word_t'(sticky));
               if (me.fault) sticky = 1'b1;
               log_q.push_back(8'h49);
            end
         end
         if (ramREN || ramWEN) begin
            if (ramstate == ACCESS || ramstate == ERROR) begin
               if (ramWEN && ramstate == ACCESS) mem[ramaddr[3:0]] = ramstore;
               busy_left = (force_lat >= 0) ? force_lat : int'($urandom_range(3, 0));
            end else if (busy_left > 0) begin
               busy_left--;
            end
         end
      end
   end

   // RAM status for the new cycle, presented after the grant has settled.
   always @(posedge CLK) begin
      #2;
      if (hang || busy_left != 0) ramstate = BUSY;
      else if (err_mode && ramaddr[2:0] == 3'd7) ramstate = ERROR;
      else ramstate = ACCESS;
   end

   task automatic d_issue(input bit wr, input word_t a, input word_t v, input bit to,
                          output int en);
      exp_t e;
      bit   flt;
      bit   done;
      flt       = to || (err_mode && a[2:0] == 3'd7);
      e.is_read = !wr;
      e.fault   = flt;
      e.load    = flt ? ERR_W : model[a[3:0]];
      if (wr && !flt) model[a[3:0]] = v;
      dq.push_back(e);
      @(posedge CLK); #1;
      dREN = !wr; dWEN = wr; daddr = a; dstore = v;
      en = 0; done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge CLK);
         if ((ramREN || ramWEN) && ramaddr == daddr) en++;
         if (!dwait) done = 1;
      end
      if (!done) begin
         tests++; failed++;
         $display("FAIL d_handshake: got no dwait pulse in 200 cycles, expected completion");
      end
   endtask

   task automatic i_issue(input word_t a, output int en);
      exp_t e;
      bit   flt;
      bit   done;
      flt       = err_mode && a[2:0] == 3'd7;
      e.is_read = 1'b1;
      e.fault   = flt;
      e.load    = flt ? ERR_W : model[a[3:0]];
      iq.push_back(e);
      @(posedge CLK); #1;
      iREN = 1'b1; iaddr = a;
      en = 0; done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge CLK);
         if (ramREN && ramaddr == iaddr) en++;
         if (!iwait) done = 1;
      end
      if (!done) begin
         tests++; failed++;
         $display("FAIL i_handshake: got no iwait pulse in 200 cycles, expected completion");
      end
   endtask

   task automatic d_idle();
      @(posedge CLK); #1;
      dREN = 1'b0; dWEN = 1'b0;
   endtask

   task automatic i_idle();
      @(posedge CLK); #1;
      iREN = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int    en;
      int    cyc;
      string pat;
      exp_t  e;
      for (int i = 0; i < 16; i++) begin
         mem[i]   = $urandom;
         model[i] = mem[i];
      end

      // Reset values
      repeat (3) @(posedge CLK);
      #3;
      chk("rst_iwait", word_t'(iwait), 32'd1);
      chk("rst_dwait", word_t'(dwait), 32'd1);
      chk("rst_ramREN", word_t'(ramREN), 32'd0);
      chk("rst_ramWEN", word_t'(ramWEN), 32'd0);
      chk("rst_ramaddr", ramaddr, 32'd0);
      chk("rst_ramstore", ramstore, 32'd0);
      chk("rst_iload", iload, 32'd0);
      chk("rst_dload", dload, 32'd0);
      chk("rst_err", word_t'(err), 32'd0);
      @(negedge CLK); RST = 1'b0;

      // Reset pulsed mid-grant
      hang = 1;
      @(posedge CLK); #1; dREN = 1'b1; daddr = 32'h1;
      repeat (3) @(negedge CLK);
      chk("midrst_granted", word_t'(ramREN), 32'd1);
      #2 RST = 1'b1; #1;
      chk("midrst_dwait", word_t'(dwait), 32'd1);
      chk("midrst_iwait", word_t'(iwait), 32'd1);
      chk("midrst_ramREN", word_t'(ramREN), 32'd0);
      chk("midrst_ramWEN", word_t'(ramWEN), 32'd0);
      chk("midrst_err", word_t'(err), 32'd0);
      dREN = 1'b0;
      @(negedge CLK); RST = 1'b0; hang = 0; busy_left = 0;

      // Read with three BUSY cycles before ACCESS
      mem[0] = 32'hDEADBEEF; model[0] = 32'hDEADBEEF;
      busy_left = 3; force_lat = 0;
      d_issue(1'b0, 32'h40, 32'h0, 1'b0, en);
      chk("busy3_grant_cycles", word_t'(en), 32'd4);
      d_idle();

      // Simultaneous write and instruction read: data wins
      e.is_read = 0; e.fault = 0; e.load = '0; dq.push_back(e);
      model[0] = 32'h12345678;
      e.is_read = 1; e.load = 32'h12345678; iq.push_back(e);
      @(posedge CLK); #1;
      dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678; iREN = 1'b1; iaddr = 32'h0;
      @(negedge CLK);
      chk("sim_idle_en", word_t'(ramREN | ramWEN), 32'd0);
      @(negedge CLK);
      chk("sim_ramWEN", word_t'(ramWEN), 32'd1);
      chk("sim_ramstore", ramstore, 32'h12345678);
      chk("sim_ramaddr_d", ramaddr, 32'h80);
      chk("sim_dwait", word_t'(dwait), 32'd0);
      chk("sim_iwait_held", word_t'(iwait), 32'd1);
      @(posedge CLK); #1; dWEN = 1'b0;
      @(negedge CLK);
      chk("sim_gap_en", word_t'(ramREN | ramWEN), 32'd0);
      chk("sim_gap_iwait", word_t'(iwait), 32'd1);
      @(negedge CLK);
      chk("sim_ramREN_i", word_t'(ramREN), 32'd1);
      chk("sim_ramaddr_i", ramaddr, 32'h0);
      chk("sim_iwait", word_t'(iwait), 32'd0);
      @(posedge CLK); #1; iREN = 1'b0;

      // Starvation bound: four data completions, then one instruction
      for (int k = 0; k < 8; k++) begin
         e.is_read = 1; e.fault = 0; e.load = model[1]; dq.push_back(e);
      end
      for (int k = 0; k < 2; k++) begin
         e.is_read = 1; e.fault = 0; e.load = model[9]; iq.push_back(e);
      end
      log_q.delete();
      @(posedge CLK); #1;
      dREN = 1'b1; daddr = 32'h1; iREN = 1'b1; iaddr = 32'h9;
      cyc = 0;
      while (log_q.size() < 10 && cyc < 100) begin
         @(negedge CLK); #1; cyc++;
      end
      @(posedge CLK); #1; dREN = 1'b0; iREN = 1'b0;
      pat = "DDDDIDDDDI";
      if (log_q.size() < 10) begin
         tests++; failed++;
         $display("FAIL starve_count: got %0d completions, expected 10", log_q.size());
      end else begin
         for (int k = 0; k < 10; k++) chk("starve_order", word_t'(log_q[k]), word_t'(pat[k]));
      end

      // Requester drop after two BUSY cycles
      hang = 1;
      @(posedge CLK); #1; dREN = 1'b1; daddr = 32'h3;
      repeat (3) @(negedge CLK);
      @(posedge CLK); #1; dREN = 1'b0;
      @(negedge CLK);
      chk("drop_dwait", word_t'(dwait), 32'd1);
      chk("drop_en", word_t'(ramREN | ramWEN), 32'd0);
      @(negedge CLK);
      chk("drop_idle_dwait", word_t'(dwait), 32'd1);
      chk("drop_err", word_t'(err), 32'd0);
      hang = 0; busy_left = 0;

      // Timeout with RAM stuck BUSY, then err stays set
      hang = 1;
      d_issue(1'b0, 32'h2, 32'h0, 1'b1, en);
      chk("timeout_cycles", word_t'(en), 32'd64);
      hang = 0; busy_left = 0;
      d_idle();
      @(negedge CLK);
      chk("timeout_err", word_t'(err), 32'd1);
      d_issue(1'b0, 32'h5, 32'h0, 1'b0, en);
      d_idle();
      @(negedge CLK);
      chk("err_sticky", word_t'(err), 32'd1);

      // Randomized concurrent traffic with faulty addresses
      @(negedge CLK); RST = 1'b1; sticky = 0;
      @(negedge CLK); RST = 1'b0;
      err_mode = 1; force_lat = -1;
      fork
         begin : data_side
            int den;
            for (int n = 0; n < 60; n++) begin
               d_issue(bit'($urandom_range(1, 0)), word_t'($urandom_range(7, 0)), $urandom, 1'b0, den);
               if ($urandom_range(2, 0) == 0) begin
                  d_idle();
                  repeat ($urandom_range(3, 0)) @(posedge CLK);
               end
            end
            d_idle();
         end
         begin : instr_side
            int ien;
            for (int n = 0; n < 60; n++) begin
               i_issue(word_t'($urandom_range(15, 8)), ien);
               if ($urandom_range(2, 0) == 0) begin
                  i_idle();
                  repeat ($urandom_range(3, 0)) @(posedge CLK);
               end
            end
            i_idle();
         end
      join
      repeat (3) @(negedge CLK);
      chk("dq_drained", word_t'(dq.size()), 32'd0);
      chk("iq_drained", word_t'(iq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
